concurrent_id_retirer: RTL and testbench



---
 rtl/concurrent_id_retirer.sv | 122 ++++++++++++
 tb/tb_concurrent_id_retirer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/concurrent_id_retirer.sv
// Return path for concurrently issued task IDs: round-robin accepts one release per cycle,
// records completions in a bitmap, flags double releases and advances an in-order watermark.
module concurrent_id_retirer #(
  parameter int unsigned NUM_ACCS = 16,
  parameter int unsigned ID_BITS  = 8,
  localparam int unsigned PortW   = (NUM_ACCS > 1) ? $clog2(NUM_ACCS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_ACCS-1:0]          release_valid,
  input  logic [NUM_ACCS*ID_BITS-1:0]  release_id,
  output logic [NUM_ACCS-1:0]          release_ready,
  output logic [ID_BITS-1:0]           watermark,
  output logic [31:0]                  wrap_count,
  output logic [31:0]                  retired_count,
  output logic                         err_valid,
  output logic [PortW-1:0]             err_port,
  output logic [ID_BITS-1:0]           err_id,
  output logic                         drained
);

  localparam int unsigned IdSpace = 1 << ID_BITS;

  logic [IdSpace-1:0] bitmap_q, bitmap_d;
  logic [ID_BITS-1:0] wm_q, wm_d;
  logic [31:0]        wrap_q, wrap_d;
  logic [31:0]        retired_q, retired_d;
  logic               err_valid_q, err_valid_d;
  logic [PortW-1:0]   err_port_q, err_port_d;
  logic [ID_BITS-1:0] err_id_q, err_id_d;
  logic [PortW-1:0]   rr_q, rr_d;

  logic [NUM_ACCS-1:0] grant;
  logic [PortW-1:0]    gnt_idx;
  logic [PortW-1:0]    cand;
  logic                gnt_any;
  logic                xfer;
  logic [ID_BITS-1:0]  sel_id;

  // Search upward from the round-robin pointer, wrapping modulo NUM_ACCS.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_ACCS; k++) begin
      cand = PortW'((32'(rr_q) + k) % NUM_ACCS);
      if (!gnt_any && release_valid[cand]) begin
        gnt_any       = 1'b1;
        gnt_idx       = cand;
        grant[cand]   = 1'b1;
      end
    end
  end

  assign xfer          = gnt_any & ~rst;
  assign release_ready = rst ? '0 : grant;
  assign sel_id        = release_id[32'(gnt_idx) * ID_BITS +: ID_BITS];

  always_comb begin
    bitmap_d    = bitmap_q;
    wm_d        = wm_q;
    wrap_d      = wrap_q;
    retired_d   = retired_q;
    err_valid_d = 1'b0;
    err_port_d  = err_port_q;
    err_id_d    = err_id_q;
    rr_d        = rr_q;

    // Advance looks only at registered state, so an accept at the watermark waits one edge.
    if (bitmap_q[wm_q]) begin
      bitmap_d[wm_q] = 1'b0;
      wm_d           = wm_q + ID_BITS'(1);
      if (wm_q == '1) begin
        wrap_d = wrap_q + 32'd1;
      end
    end

    if (xfer) begin
      rr_d = (32'(gnt_idx) == NUM_ACCS - 1) ? '0 : gnt_idx + PortW'(1);
      if (bitmap_q[sel_id]) begin
        err_valid_d = 1'b1;
        err_port_d  = gnt_idx;
        err_id_d    = sel_id;
      end else begin
        bitmap_d[sel_id] = 1'b1;
        retired_d        = retired_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap_q    <= '0;
      wm_q        <= '0;
      wrap_q      <= '0;
      retired_q   <= '0;
      err_valid_q <= 1'b0;
      err_port_q  <= '0;
      err_id_q    <= '0;
      rr_q        <= '0;
    end else begin
      bitmap_q    <= bitmap_d;
      wm_q        <= wm_d;
      wrap_q      <= wrap_d;
      retired_q   <= retired_d;
      err_valid_q <= err_valid_d;
      err_port_q  <= err_port_d;
      err_id_q    <= err_id_d;
      rr_q        <= rr_d;
    end
  end

  assign watermark     = wm_q;
  assign wrap_count    = wrap_q;
  assign retired_count = retired_q;
  assign err_valid     = err_valid_q;
  assign err_port      = err_port_q;
  assign err_id        = err_id_q;
  assign drained       = ~|bitmap_q;

endmodule

// File: tb/tb_concurrent_id_retirer.sv
// Directed bench for concurrent_id_retirer: default 8-bit instance plus a 4-bit instance for wrap.
module tb_concurrent_id_retirer;

  logic         clk;
  logic         rst;
  logic [15:0]  rv;
  logic [127:0] rid;
  logic [15:0]  ready;
  logic [7:0]   wm;
  logic [31:0]  wrap, retired;
  logic         err_valid;
  logic [3:0]   err_port;
  logic [7:0]   err_id;
  logic         drained;

  logic [15:0]  rv4;
  logic [63:0]  rid4;
  logic [15:0]  ready4;
  logic [3:0]   wm4;
  logic [31:0]  wrap4, retired4;
  logic         err_valid4;
  logic [3:0]   err_port4;
  logic [3:0]   err_id4;
  logic         drained4;

  int n_tests = 0;
  int n_fail  = 0;
  int err4_cnt = 0;
  bit done;

  concurrent_id_retirer #(.NUM_ACCS(16), .ID_BITS(8)) dut (
    .clk(clk), .rst(rst), .release_valid(rv), .release_id(rid), .release_ready(ready),
    .watermark(wm), .wrap_count(wrap), .retired_count(retired), .err_valid(err_valid),
    .err_port(err_port), .err_id(err_id), .drained(drained)
  );

  concurrent_id_retirer #(.NUM_ACCS(16), .ID_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .release_valid(rv4), .release_id(rid4), .release_ready(ready4),
    .watermark(wm4), .wrap_count(wrap4), .retired_count(retired4), .err_valid(err_valid4),
    .err_port(err_port4), .err_id(err_id4), .drained(drained4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (err_valid4) err4_cnt <= err4_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rv  = '0;
    rv4 = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    bit          pat6 [6];
    logic [15:0] exp6 [6];
    pat6 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp6 = '{16'h1, 16'h2, 16'h1, 16'h2, 16'h1, 16'h2};

    rst = 1'b1; rv = '0; rid = '0; rv4 = '0; rid4 = '0;
    step(); step();
    check("rst_wm", wm, 0);
    check("rst_retired", retired, 0);
    check("rst_wrap", wrap, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_port", err_port, 0);
    check("rst_err_id", err_id, 0);
    check("rst_drained", drained, 1);
    rv[3] = 1'b1; rid[3*8 +: 8] = 8'd0; #1;
    check("rst_ready_low", ready, 0);

    // Single release of ID 0 from port 3
    rst = 1'b0; #1;
    check("t1_ready", ready, 16'h0008);
    step(); rv = '0;
    check("t1_retired", retired, 1);
    check("t1_wm0", wm, 0);
    check("t1_busy", drained, 0);
    step();
    check("t1_wm1", wm, 1);
    check("t1_drained", drained, 1);

    // Three simultaneous requesters, granted in rotation
    do_reset();
    rv = 16'h8021; rid[0 +: 8] = 8'd2; rid[40 +: 8] = 8'd1; rid[120 +: 8] = 8'd0; #1;
    check("t2_g0", ready, 16'h0001);
    step(); rv[0] = 1'b0; #1;
    check("t2_g5", ready, 16'h0020);
    step(); rv[5] = 1'b0; #1;
    check("t2_g15", ready, 16'h8000);
    check("t2_retired2", retired, 2);
    check("t2_wm_hold", wm, 0);
    step(); rv[15] = 1'b0; #1;
    check("t2_retired3", retired, 3);
    check("t2_wm0", wm, 0);
    step(); check("t2_wm1", wm, 1);
    step(); check("t2_wm2", wm, 2);
    step(); check("t2_wm3", wm, 3);
    check("t2_drained", drained, 1);

    // Double release of ID 7 from port 2
    do_reset();
    rv[2] = 1'b1; rid[16 +: 8] = 8'd7; #1;
    check("t3_ready_a", ready, 16'h0004);
    step();
    check("t3_retired_a", retired, 1);
    check("t3_ready_b", ready, 16'h0004);
    step(); rv = '0; #1;
    check("t3_err_valid", err_valid, 1);
    check("t3_err_port", err_port, 2);
    check("t3_err_id", err_id, 7);
    check("t3_retired_b", retired, 1);
    step();
    check("t3_err_pulse", err_valid, 0);
    check("t3_err_port_hold", err_port, 2);
    check("t3_err_id_hold", err_id, 7);
    check("t3_bit7_set", drained, 0);
    check("t3_wm", wm, 0);

    // Mid-stream reset with bits 1..5 (and 7) set
    rv[4] = 1'b1;
    for (int id = 1; id <= 5; id++) begin
      rid[32 +: 8] = 8'(id);
      step();
    end
    check("t5_retired", retired, 6);
    check("t5_busy", drained, 0);
    rst = 1'b1; #1;
    check("t5_ready_rst", ready, 0);
    step();
    rst = 1'b0; rv = 16'h0101; #1;
    check("t5_wm", wm, 0);
    check("t5_retired0", retired, 0);
    check("t5_err_port", err_port, 0);
    check("t5_err_id", err_id, 0);
    check("t5_drained", drained, 1);
    check("t5_rr_ptr0", ready, 16'h0001);
    rv = '0;

    // Port 1 held, port 0 pulsed: grants alternate
    do_reset();
    rv[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rv[0] = pat6[i]; #1;
      check($sformatf("t6_grant%0d", i), ready, exp6[i]);
      step();
    end
    rv = '0;

    // 4-bit ID space: reverse release of 0..15, drain with wrap, then 0..3 again
    do_reset();
    rv4[0] = 1'b1;
    for (int k = 15; k >= 0; k--) begin
      rid4[3:0] = 4'(k);
      step();
    end
    rv4 = '0;
    check("t4_retired16", retired4, 16);
    check("t4_wm_start", wm4, 0);
    done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (wm4 == 4'd0 && drained4) begin
        done = 1'b1;
        break;
      end
    end
    check("t4_drain_done", done, 1);
    check("t4_wrap1", wrap4, 1);
    rv4[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rid4[3:0] = 4'(k);
      step();
    end
    rv4 = '0;
    repeat (6) step();
    check("t4_wm_final", wm4, 4);
    check("t4_wrap_final", wrap4, 1);
    check("t4_retired20", retired4, 20);
    check("t4_drained", drained4, 1);
    check("t4_no_errors", err4_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
